hall_sensor_emulator: RTL and testbench
=======================================

HALL_SENSOR_EMULATOR -- requirements
Module: hall_sensor_emulator

Interface
REQ-001 SHALL have parameter clk_freq_hz, default 50_000_000, meaning clock frequency in Hz (documentation and bench timing only).
REQ-002 SHALL have parameter period_width, default 24, meaning width of step_period in bits.
REQ-003 SHALL have parameter bounce_toggles, default 6, meaning number of glitch toggles injected per transition; must be even.
REQ-004 SHALL have parameter bounce_gap, default 4, meaning clock cycles between glitch toggles; minimum 1.
REQ-005 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  run emulation when high.
REQ-008 SHALL have port direction  in  1  0 = forward (sector+1), 1 = reverse (sector-1).
REQ-009 SHALL have port step_period  in  period_width  clock cycles per sector; 0 = hold.
REQ-010 SHALL have port bounce_en  in  1  inject contact bounce on each hall transition.
REQ-011 SHALL have port hall_a, hall_b, hall_c  out  1 each  emulated hall lines.
REQ-012 SHALL have port sector  out  3  current sector, 0..5.
REQ-013 SHALL have port step_strobe  out  1  one-cycle pulse on each sector advance.
REQ-014 SHALL have port settled  out  1  high when hall lines equal the clean code of sector.

Function
REQ-015 Sector-to-hall mapping {a,b,c} SHALL be: 0=101, 1=100, 2=110, 3=010, 4=011, 5=001.
REQ-016 Sector SHALL wrap 5->0 forward and 0->5 reverse.
REQ-017 FSM states SHALL be IDLE, RUN and BOUNCE.
REQ-018 IDLE->RUN SHALL occur when enable=1 and step_period!=0.
REQ-019 RUN->BOUNCE SHALL occur on advance when bounce_en=1 and bounce_toggles*bounce_gap < step_period; otherwise the state SHALL remain RUN.
REQ-020 BOUNCE->RUN SHALL occur after the last toggle.
REQ-021 Any state->IDLE SHALL occur when enable=0 or step_period=0.
REQ-022 The period counter SHALL increment each cycle in RUN and BOUNCE; when counter >= step_period-1 the sector SHALL advance, step_strobe SHALL pulse in that same cycle, and the counter SHALL clear.
REQ-023 A lowered step_period SHALL take effect immediately: a counter already >= new step_period-1 SHALL advance on the next cycle.
REQ-024 Hall outputs SHALL be registered: the new clean code SHALL appear the cycle after step_strobe.
REQ-025 During BOUNCE, only the single hall line that changes SHALL toggle, starting at the new value and alternating every bounce_gap cycles for bounce_toggles toggles; it SHALL end at the new value; settled SHALL be 0 throughout.
REQ-026 A direction change SHALL affect only the next advance and SHALL never skip or repeat a sector.
REQ-027 In IDLE, the counter SHALL clear, sector SHALL freeze, the hall lines SHALL show the clean code of sector, and settled SHALL be 1.
REQ-028 Dropping enable during BOUNCE SHALL abort the glitch train within one cycle.
REQ-029 step_period=1 SHALL advance every cycle with bounce suppressed.
REQ-030 The counter SHALL be period_width bits and saturate-compare without overflow.

Reset
REQ-031 While reset=1 (asynchronous), state SHALL be IDLE, sector=0, counter=0, {hall_a,hall_b,hall_c}=101, step_strobe=0, settled=1, and bounce counters=0.
REQ-032 After reset deasserts, the first advance SHALL occur no earlier than step_period cycles after entering RUN.

Structure
REQ-033 sector_t (3-bit), hall_code_t (3-bit) and function sector_to_hall SHALL live in the shared bldc types package and be reused by hall decoding blocks.
REQ-034 Glitch generation SHALL be one sub-module, hall_bounce_gen, taking start, the old and new line values, and enable, and producing line_out and done.

Verification
REQ-035 Forward run: enable=1, step_period=10, bounce_en=0 -> step_strobe every 10 cycles; hall sequence 101,100,110,010,011,001,101; exactly one line changes per step.
REQ-036 Reverse run: direction=1 from sector 0 -> sector 5 then 4; hall 001 then 011.
REQ-037 Bounce: step_period=100, bounce_en=1 (6 toggles, gap 4) -> changing line toggles 6 times over 24 cycles, settled=0 during the train, final value equals clean code; a 50 µs debounce_us instance downstream outputs a single clean edge.
REQ-038 Suppression: step_period=20, bounce_en=1 -> no glitches, clean steps every 20 cycles.
REQ-039 Abort: enable dropped mid-BOUNCE -> next cycle shows clean code, settled=1, IDLE, sector unchanged.
REQ-040 Async reset mid-run at sector 3 -> outputs 101, sector 0, with no clock edge required.

Source files
------------

// File: rtl/bldc_types_pkg.sv
// rtl/bldc_types_pkg.sv - shared BLDC sector/hall types and helpers
// Used by the hall emulator and by hall decoding blocks.
package bldc_types_pkg;

  typedef logic [2:0] sector_t;
  typedef logic [2:0] hall_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BOUNCE = 2'd2
  } emu_state_t;

  localparam sector_t    SECTOR_LAST = 3'd5;
  localparam hall_code_t HALL_RESET  = 3'b101;

  // {a,b,c} per sector; adjacent sectors differ in exactly one line
  function automatic hall_code_t sector_to_hall(input sector_t s);
    hall_code_t h;
    case (s)
      3'd0:    h = 3'b101;
      3'd1:    h = 3'b100;
      3'd2:    h = 3'b110;
      3'd3:    h = 3'b010;
      3'd4:    h = 3'b011;
      3'd5:    h = 3'b001;
      default: h = 3'b101;
    endcase
    return h;
  endfunction

  function automatic sector_t sector_step(input sector_t s, input logic reverse);
    sector_t n;
    if (reverse) n = (s == 3'd0) ? SECTOR_LAST : s - 3'd1;
    else         n = (s >= SECTOR_LAST) ? 3'd0 : s + 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/hall_bounce_gen.sv
// rtl/hall_bounce_gen.sv - contact bounce train for one hall line
// Starts at the new value, alternates every bounce_gap cycles, ends at the new value.
module hall_bounce_gen #(
  parameter int bounce_toggles = 6,
  parameter int bounce_gap     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic old_val,
  input  logic new_val,
  input  logic enable,
  output logic line_out,
  output logic done
);

  localparam int gap_w = (bounce_gap > 1) ? $clog2(bounce_gap) : 1;
  localparam int tog_w = (bounce_toggles > 1) ? $clog2(bounce_toggles) : 1;

  logic             busy_q, busy_d;
  logic             line_q, line_d;
  logic             old_q, old_d;
  logic             new_q, new_d;
  logic [gap_w-1:0] gap_q, gap_d;
  logic [tog_w-1:0] tog_q, tog_d;
  logic             gap_end, last_tog;

  assign gap_end  = (gap_q == gap_w'(bounce_gap - 1));
  assign last_tog = (tog_q == tog_w'(bounce_toggles - 1));
  assign done     = busy_q && gap_end && last_tog;
  assign line_out = line_q;

  always_comb begin
    busy_d = busy_q;
    line_d = line_q;
    old_d  = old_q;
    new_d  = new_q;
    gap_d  = gap_q;
    tog_d  = tog_q;
    if (!enable) begin
      busy_d = 1'b0;
      line_d = new_q;
      gap_d  = '0;
      tog_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      line_d = new_val;
      old_d  = old_val;
      new_d  = new_val;
      gap_d  = '0;
      tog_d  = '0;
    end else if (busy_q) begin
      if (gap_end) begin
        gap_d  = '0;
        tog_d  = tog_q + 1'b1;
        line_d = (line_q == new_q) ? old_q : new_q;
        if (last_tog) begin
          busy_d = 1'b0;
          tog_d  = '0;
        end
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      line_q <= 1'b0;
      old_q  <= 1'b0;
      new_q  <= 1'b0;
      gap_q  <= '0;
      tog_q  <= '0;
    end else begin
      busy_q <= busy_d;
      line_q <= line_d;
      old_q  <= old_d;
      new_q  <= new_d;
      gap_q  <= gap_d;
      tog_q  <= tog_d;
    end
  end

endmodule

// File: rtl/hall_sensor_emulator.sv
// rtl/hall_sensor_emulator.sv - six-step hall sensor emulator with optional contact bounce
// Steps the sector every step_period cycles and drives registered hall lines.
module hall_sensor_emulator
  import bldc_types_pkg::*;
#(
  parameter int clk_freq_hz    = 50_000_000,
  parameter int period_width   = 24,
  parameter int bounce_toggles = 6,
  parameter int bounce_gap     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    direction,
  input  logic [period_width-1:0] step_period,
  input  logic                    bounce_en,
  output logic                    hall_a,
  output logic                    hall_b,
  output logic                    hall_c,
  output logic [2:0]              sector,
  output logic                    step_strobe,
  output logic                    settled
);

  // Illegal bounce configurations fall back to clean steps
  localparam logic cfg_ok = (clk_freq_hz > 0) && (bounce_gap >= 1) &&
                            (bounce_toggles > 0) && (bounce_toggles % 2 == 0);
  localparam logic [period_width:0] bounce_span = (period_width + 1)'(bounce_toggles * bounce_gap);

  emu_state_t              state_q, state_d;
  logic [period_width-1:0] cnt_q, cnt_d;
  sector_t                 sector_q, sector_d;
  hall_code_t              hall_q, hall_d;
  hall_code_t              mask_q, mask_d;
  hall_code_t              diff, hall_out;
  logic                    run_ok, advance, bounce_ok, bnc_start, bnc_en;
  logic                    bnc_line, bnc_done;

  assign run_ok    = enable && (step_period != '0);
  assign advance   = (state_q != ST_IDLE) && run_ok && (cnt_q >= step_period - 1'b1);
  assign bounce_ok = cfg_ok && bounce_en && ({1'b0, step_period} > bounce_span);
  assign bnc_start = advance && bounce_ok;
  assign bnc_en    = (state_d == ST_BOUNCE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (run_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!run_ok)        state_d = ST_IDLE;
        else if (bnc_start) state_d = ST_BOUNCE;
      end
      ST_BOUNCE: begin
        // A new advance mid-train (shortened period) restarts or cancels the train
        if (!run_ok)       state_d = ST_IDLE;
        else if (advance)  state_d = bounce_ok ? ST_BOUNCE : ST_RUN;
        else if (bnc_done) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sector_d = sector_q;
    cnt_d    = cnt_q;
    if (state_q == ST_IDLE || !run_ok) begin
      cnt_d = '0;
    end else if (advance) begin
      cnt_d    = '0;
      sector_d = sector_step(sector_q, direction);
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
    hall_d = sector_to_hall(sector_d);
    diff   = hall_q ^ hall_d;
    mask_d = bnc_start ? diff : mask_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      sector_q <= '0;
      hall_q   <= HALL_RESET;
      mask_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      sector_q <= sector_d;
      hall_q   <= hall_d;
      mask_q   <= mask_d;
    end
  end

  hall_bounce_gen #(
    .bounce_toggles (bounce_toggles),
    .bounce_gap     (bounce_gap)
  ) u_bounce (
    .clk      (clk),
    .reset    (reset),
    .start    (bnc_start),
    .old_val  (|(hall_q & diff)),
    .new_val  (|(hall_d & diff)),
    .enable   (bnc_en),
    .line_out (bnc_line),
    .done     (bnc_done)
  );

  always_comb begin
    hall_out = hall_q;
    if (state_q == ST_BOUNCE) hall_out = (hall_q & ~mask_q) | (bnc_line ? mask_q : 3'b000);
    step_strobe = advance;
    settled     = (state_q != ST_BOUNCE) && (hall_out == sector_to_hall(sector_q));
    {hall_a, hall_b, hall_c} = hall_out;
    sector      = sector_q;
  end

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// tb/tb_hall_sensor_emulator.sv - self-checking bench for hall_sensor_emulator
module tb_hall_sensor_emulator;

  localparam int pw = 24;

  logic          clk = 1'b0;
  logic          reset, enable, direction, bounce_en;
  logic [pw-1:0] step_period;
  logic          hall_a, hall_b, hall_c, step_strobe, settled;
  logic [2:0]    sector;
  logic [2:0]    hall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       dir;
    int         period;
    logic       bnc;
    int         steps;
    int         exp_unsettled;
  } run_t;

  typedef struct {
    logic [2:0] sector;
    logic [2:0] hall;
  } exp_t;

  run_t       rows[6];
  logic [2:0] hall_tab[6];
  logic [2:0] model_sector;
  exp_t       sb[$];

  hall_sensor_emulator #(
    .clk_freq_hz    (50_000_000),
    .period_width   (pw),
    .bounce_toggles (6),
    .bounce_gap     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .direction   (direction),
    .step_period (step_period),
    .bounce_en   (bounce_en),
    .hall_a      (hall_a),
    .hall_b      (hall_b),
    .hall_c      (hall_c),
    .sector      (sector),
    .step_strobe (step_strobe),
    .settled     (settled)
  );

  always #5 clk = ~clk;
  assign hall = {hall_a, hall_b, hall_c};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] next_sector(input logic [2:0] s, input logic rev);
    if (rev) return (s == 3'd0) ? 3'd5 : s - 3'd1;
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  task automatic wait_strobe(input string name, input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!step_strobe && cyc < budget);
    check(name, step_strobe, 1'b1);
  endtask

  task automatic run_row(input run_t r);
    int         cyc, since, seen, unsettled, budget;
    logic [2:0] prev;
    exp_t       e;
    cyc = 0; since = 0; seen = 0; unsettled = 0;
    budget = r.steps * r.period + 20;
    prev = hall_tab[model_sector];
    direction = r.dir; step_period = pw'(r.period); bounce_en = r.bnc; enable = 1'b1;
    while (seen < r.steps && cyc < budget) begin
      @(negedge clk);
      cyc++; since++;
      if (!settled) unsettled++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_sector", sector, e.sector);
        check("sb_hall", hall, e.hall);
        check("one_line_change", $countones(hall ^ prev), 1);
        prev = hall;
      end
      if (step_strobe) begin
        check("strobe_interval", since, r.period);
        since = 0; seen++;
        model_sector = next_sector(model_sector, r.dir);
        sb.push_back('{model_sector, hall_tab[model_sector]});
      end
    end
    check("row_in_budget", seen, r.steps);
    @(negedge clk);
    if (!settled) unsettled++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_sector_last", sector, e.sector);
      check("sb_hall_last", hall, e.hall);
    end
    enable = 1'b0;
    check("unsettled_cycles", unsettled, r.exp_unsettled);
    @(negedge clk);
    check("idle_sector", sector, model_sector);
    check("idle_hall", hall, hall_tab[model_sector]);
    check("idle_settled", settled, 1'b1);
    @(negedge clk);
    check("idle_frozen", {step_strobe, sector}, {1'b0, model_sector});
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int         cyc, tog, uns, other_bad;
    logic [2:0] old_code, new_code, mask, prevh;

    hall_tab[0] = 3'b101; hall_tab[1] = 3'b100; hall_tab[2] = 3'b110;
    hall_tab[3] = 3'b010; hall_tab[4] = 3'b011; hall_tab[5] = 3'b001;
    rows[0] = '{1'b0, 10,  1'b0, 6, 0};
    rows[1] = '{1'b1, 10,  1'b0, 2, 0};
    rows[2] = '{1'b0, 20,  1'b1, 3, 0};
    rows[3] = '{1'b1, 1,   1'b1, 6, 0};
    rows[4] = '{1'b0, 100, 1'b1, 2, 25};
    rows[5] = '{1'b1, 3,   1'b0, 4, 0};

    reset = 1'b1; enable = 1'b0; direction = 1'b0; bounce_en = 1'b0; step_period = '0;
    model_sector = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_hall", hall, 3'b101);
    check("rst_sector", sector, 3'd0);
    check("rst_strobe", step_strobe, 1'b0);
    check("rst_settled", settled, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_row(rows[i]);

    // bounce train detail
    direction = 1'b0; step_period = pw'(100); bounce_en = 1'b1; enable = 1'b1;
    wait_strobe("bnc_strobe", 150, cyc);
    check("bnc_first_latency", cyc, 100);
    old_code = hall_tab[model_sector];
    model_sector = next_sector(model_sector, 1'b0);
    new_code = hall_tab[model_sector];
    mask = old_code ^ new_code;
    prevh = new_code; tog = 0; uns = 0; other_bad = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) check("bnc_starts_new", hall, new_code);
      if ((hall & mask) != (prevh & mask)) tog++;
      if ((hall & ~mask) != (new_code & ~mask)) other_bad++;
      if (!settled) uns++;
      prevh = hall;
    end
    check("bnc_toggles", tog, 6);
    check("bnc_unsettled", uns, 24);
    check("bnc_other_lines", other_bad, 0);
    check("bnc_final_hall", hall, new_code);
    check("bnc_final_settled", settled, 1'b1);
    check("bnc_sector", sector, model_sector);

    // abort mid-train
    wait_strobe("abort_strobe", 150, cyc);
    model_sector = next_sector(model_sector, 1'b0);
    repeat (5) @(negedge clk);
    check("abort_in_train", settled, 1'b0);
    enable = 1'b0;
    @(negedge clk);
    check("abort_hall", hall, hall_tab[model_sector]);
    check("abort_settled", settled, 1'b1);
    check("abort_sector", sector, model_sector);
    tog = 0;
    repeat (4) begin
      @(negedge clk);
      if (step_strobe || sector != model_sector) tog++;
    end
    check("abort_idle_hold", tog, 0);

    // lowered step_period takes effect at once
    direction = 1'b1; step_period = pw'(50); bounce_en = 1'b0; enable = 1'b1;
    wait_strobe("lower_strobe", 80, cyc);
    check("lower_first_latency", cyc, 50);
    model_sector = next_sector(model_sector, 1'b1);
    repeat (30) @(negedge clk);
    step_period = pw'(10);
    #1;
    check("lower_strobe_now", step_strobe, 1'b1);
    @(negedge clk);
    model_sector = next_sector(model_sector, 1'b1);
    check("lower_advanced", sector, model_sector);
    enable = 1'b0;
    @(negedge clk);

    // async reset mid-run at sector 3
    direction = 1'b0; step_period = pw'(10); enable = 1'b1;
    for (int k = 0; k < 6 && model_sector != 3'd3; k++) begin
      wait_strobe("run_to_3", 20, cyc);
      model_sector = next_sector(model_sector, 1'b0);
    end
    @(negedge clk);
    check("pre_reset_sector", sector, 3'd3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_hall", hall, 3'b101);
    check("async_rst_sector", sector, 3'd0);
    check("async_rst_settled", settled, 1'b1);
    check("async_rst_strobe", step_strobe, 1'b0);
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
